// File: rtl/grn_attractor_ctrl.sv
// rtl/grn_attractor_ctrl.sv - Floyd attractor search sequencer for a bank of GRN node stages
//
// Loads a seed into the node bank, steps tortoise (s0) and hare (s1) until
// they meet, optionally measures the attractor period, and reports the result
// over a valid/ready handshake.
//
// Optional feature macro: GRN_CTRL_PERIOD_EN (period measurement phase).
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   start, seed           run request (sampled in IDLE) and initial state
//   s0_in, s1_in          tortoise / hare state vectors from the nodes
//   reset_nos             node load strobe
//   start_s0, start_s1    tortoise / hare step strobes
//   init_state            captured seed driven to the nodes
//   busy                  high whenever not IDLE
//   out_valid, out_ready  result handshake
//   meet_steps, period    step count at meet, attractor length (0 on timeout)
//   timeout               step limit reached without equality

module grn_attractor_ctrl #(
   parameter int NODES     = 8,
   parameter int STEP_W    = 16,
   parameter int MAX_STEPS = 1000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [NODES-1:0]  seed,
   input  logic [NODES-1:0]  s0_in,
   input  logic [NODES-1:0]  s1_in,
   output logic              reset_nos,
   output logic              start_s0,
   output logic              start_s1,
   output logic [NODES-1:0]  init_state,
   output logic              busy,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [STEP_W-1:0] meet_steps,
   output logic [STEP_W-1:0] period,
   output logic              timeout
);

   localparam logic [STEP_W-1:0] LP_MAX_STEPS = STEP_W'(MAX_STEPS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_ISSUE,
      S_CHECK,
      S_PISSUE,
      S_PCHECK,
      S_RESULT
   } state_t;

   state_t            r_state;
   logic [NODES-1:0]  r_init_state;
   logic [STEP_W-1:0] r_step_cnt;
   logic [STEP_W-1:0] r_meet_steps;
   logic              r_reset_nos;
   logic              r_start_s0;
   logic              r_start_s1;
   logic              r_busy;
   logic              r_out_valid;
   logic              r_timeout;
   logic              w_match;
`ifdef GRN_CTRL_PERIOD_EN
   logic [STEP_W-1:0] r_per_cnt;
   logic [STEP_W-1:0] r_period;
`endif

   assign w_match = (s0_in == s1_in);

   // Strobes are registered alongside the state transition that enters the
   // state they belong to, so they are high exactly while in that state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_init_state <= '0;
         r_step_cnt   <= '0;
         r_meet_steps <= '0;
         r_reset_nos  <= 1'b0;
         r_start_s0   <= 1'b0;
         r_start_s1   <= 1'b0;
         r_busy       <= 1'b0;
         r_out_valid  <= 1'b0;
         r_timeout    <= 1'b0;
`ifdef GRN_CTRL_PERIOD_EN
         r_per_cnt    <= '0;
         r_period     <= '0;
`endif
      end else begin
         r_reset_nos <= 1'b0;
         r_start_s0  <= 1'b0;
         r_start_s1  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_init_state <= seed;
                  r_step_cnt   <= '0;
                  r_meet_steps <= '0;
                  r_timeout    <= 1'b0;
`ifdef GRN_CTRL_PERIOD_EN
                  r_per_cnt    <= '0;
                  r_period     <= '0;
`endif
                  r_reset_nos  <= 1'b1;
                  r_busy       <= 1'b1;
                  r_state      <= S_LOAD;
               end
            end
            S_LOAD: begin
               r_start_s0 <= 1'b1;
               r_start_s1 <= 1'b1;
               r_state    <= S_ISSUE;
            end
            S_ISSUE: begin
               r_step_cnt <= r_step_cnt + 1'b1;
               r_state    <= S_CHECK;
            end
            S_CHECK: begin
               if (w_match) begin
                  r_meet_steps <= r_step_cnt;
`ifdef GRN_CTRL_PERIOD_EN
                  r_start_s1   <= 1'b1;
                  r_state      <= S_PISSUE;
`else
                  r_state      <= S_RESULT;
`endif
               end else if (r_step_cnt == LP_MAX_STEPS) begin
                  r_timeout <= 1'b1;
                  r_state   <= S_RESULT;
               end else begin
                  r_start_s0 <= 1'b1;
                  r_start_s1 <= 1'b1;
                  r_state    <= S_ISSUE;
               end
            end
`ifdef GRN_CTRL_PERIOD_EN
            S_PISSUE: begin
               r_per_cnt <= r_per_cnt + 1'b1;
               r_state   <= S_PCHECK;
            end
            S_PCHECK: begin
               if (w_match) begin
                  r_period <= r_per_cnt;
                  r_state  <= S_RESULT;
               end else if (r_per_cnt == LP_MAX_STEPS) begin
                  r_timeout <= 1'b1;
                  r_period  <= '0;
                  r_state   <= S_RESULT;
               end else begin
                  r_start_s1 <= 1'b1;
                  r_state    <= S_PISSUE;
               end
            end
`endif
            S_RESULT: begin
               // The first RESULT cycle lets the result registers settle;
               // out_valid follows one cycle later and holds until taken.
               if (!r_out_valid) begin
                  r_out_valid <= 1'b1;
               end else if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_busy      <= 1'b0;
               r_out_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign reset_nos  = r_reset_nos;
   assign start_s0   = r_start_s0;
   assign start_s1   = r_start_s1;
   assign init_state = r_init_state;
   assign busy       = r_busy;
   assign out_valid  = r_out_valid;
   assign meet_steps = r_meet_steps;
   assign timeout    = r_timeout;
`ifdef GRN_CTRL_PERIOD_EN
   assign period     = r_period;
`else
   assign period     = '0;
`endif

endmodule
